chacha_keystream_core: RTL and testbench

Iterative ChaCha block-function engine that turns the session `chacha_key` and `chacha_nonce` into 512-bit keystream blocks and encrypts a 256-bit `message` by XOR with the low half of each block. It sits directly upstream of the `final_top` datapath's `message`/`Done` interface: its `ciphertext` and `Done` feed the ECC point-encoding stage. The engine performs one full round (four quarter-rounds in parallel) per clock.

---
 rtl/chacha_keystream_core.sv | 121 ++++++++++++
 tb/tb_chacha_keystream_core.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/chacha_keystream_core.sv
// chacha_keystream_core: iterative ChaCha block engine, one round per clock,
// producing a 512-bit keystream block and XOR-encrypting a 256-bit message.
module chacha_keystream_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         ctr_load,
  input  logic [31:0]  ctr_in,
  input  logic [255:0] chacha_key,
  input  logic [127:0] chacha_nonce,
  input  logic [255:0] message,
  output logic         busy,
  output logic         Done,
  output logic [511:0] keystream,
  output logic [255:0] ciphertext,
  output logic         ctr_wrap
);
  localparam int CW = $clog2(ROUNDS);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] round_cnt;
  logic [511:0] init_st, st, st_nxt, init_blk, ks;
  logic [255:0] msg;
  logic [31:0]  blk_ctr, used_ctr, ctr_sel;
  logic [31:0]  w [16];
  logic [31:0]  nw [16];

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i + b_i;
    d = rotl(d_i ^ a, 16);
    c = c_i + d;
    b = rotl(b_i ^ c, 12);
    a = a + b;
    d = rotl(d ^ a, 8);
    c = c + d;
    b = rotl(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  assign ctr_sel  = ctr_load ? ctr_in : blk_ctr;
  assign init_blk = {chacha_nonce[127:32], chacha_nonce[31:0] + ctr_sel, chacha_key,
                     32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

  for (genvar i = 0; i < 16; i++) begin : g_ks
    assign ks[32*i +: 32] = st[32*i +: 32] + init_st[32*i +: 32];
  end

  // Even rounds work on columns, odd rounds on diagonals.
  always_comb begin
    for (int i = 0; i < 16; i++) w[i] = st[32*i +: 32];
    nw = w;
    if (!round_cnt[0]) begin
      {nw[0], nw[4], nw[8],  nw[12]} = qr(w[0], w[4], w[8],  w[12]);
      {nw[1], nw[5], nw[9],  nw[13]} = qr(w[1], w[5], w[9],  w[13]);
      {nw[2], nw[6], nw[10], nw[14]} = qr(w[2], w[6], w[10], w[14]);
      {nw[3], nw[7], nw[11], nw[15]} = qr(w[3], w[7], w[11], w[15]);
    end else begin
      {nw[0], nw[5], nw[10], nw[15]} = qr(w[0], w[5], w[10], w[15]);
      {nw[1], nw[6], nw[11], nw[12]} = qr(w[1], w[6], w[11], w[12]);
      {nw[2], nw[7], nw[8],  nw[13]} = qr(w[2], w[7], w[8],  w[13]);
      {nw[3], nw[4], nw[9],  nw[14]} = qr(w[3], w[4], w[9],  w[14]);
    end
    for (int i = 0; i < 16; i++) st_nxt[32*i +: 32] = nw[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE  ? (start ? ROUND : IDLE) :
                state == ROUND ? (round_cnt == CW'(ROUNDS - 1) ? FINAL : ROUND) : IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_st    <= '0;
      st         <= '0;
      round_cnt  <= '0;
      msg        <= '0;
      used_ctr   <= '0;
      blk_ctr    <= '0;
      busy       <= 1'b0;
      Done       <= 1'b0;
      keystream  <= '0;
      ciphertext <= '0;
      ctr_wrap   <= 1'b0;
    end else begin
      Done <= state == FINAL;
      if (state == IDLE && start) begin
        init_st   <= init_blk;
        st        <= init_blk;
        round_cnt <= '0;
        msg       <= message;
        used_ctr  <= ctr_sel;
        busy      <= 1'b1;
        if (ctr_load) ctr_wrap <= 1'b0;
      end
      if (state == ROUND) begin
        st        <= st_nxt;
        round_cnt <= round_cnt + CW'(1);
      end
      if (state == FINAL) begin
        keystream  <= ks;
        ciphertext <= msg ^ ks[255:0];
        busy       <= 1'b0;
        blk_ctr    <= used_ctr + 32'd1;
        if (&used_ctr) ctr_wrap <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_chacha_keystream_core.sv
// tb_chacha_keystream_core: randomized and directed checks of the ChaCha core
// against a transaction-level reference model.
module tb_chacha_keystream_core;
  localparam int R = 20;
  logic clk = 0, reset_n = 0, start = 0, ctr_load = 0;
  logic [31:0]  ctr_in = 0;
  logic [255:0] chacha_key = 0, message = 0;
  logic [127:0] chacha_nonce = 0;
  logic busy, Done, ctr_wrap;
  logic [511:0] keystream;
  logic [255:0] ciphertext;
  int total = 0, bad = 0;

  chacha_keystream_core #(.ROUNDS(R)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ctr_load(ctr_load), .ctr_in(ctr_in),
    .chacha_key(chacha_key), .chacha_nonce(chacha_nonce), .message(message),
    .busy(busy), .Done(Done), .keystream(keystream), .ciphertext(ciphertext), .ctr_wrap(ctr_wrap)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [511:0] chacha(input logic [255:0] k, input logic [127:0] n, input logic [31:0] c);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] a, b, cc, d;
    int q [8][4];
    logic [511:0] o;
    q = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
          '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = n[31:0] + c; s[13] = n[63:32]; s[14] = n[95:64]; s[15] = n[127:96];
    x = s;
    for (int r = 0; r < R; r++)
      for (int j = 0; j < 4; j++) begin
        int t;
        t = (r % 2) * 4 + j;
        a = x[q[t][0]]; b = x[q[t][1]]; cc = x[q[t][2]]; d = x[q[t][3]];
        a += b; d = rol(d ^ a, 16); cc += d; b = rol(b ^ cc, 12);
        a += b; d = rol(d ^ a, 8);  cc += d; b = rol(b ^ cc, 7);
        x[q[t][0]] = a; x[q[t][1]] = b; x[q[t][2]] = cc; x[q[t][3]] = d;
      end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: a block accepted at an edge completes 21 edges later.
  int m_left = 0;
  logic m_busy = 0, m_done = 0, m_wrap = 0;
  logic [31:0] m_ctr = 0, p_ctr = 0;
  logic [511:0] m_ks = 0, p_ks = 0;
  logic [255:0] m_ct = 0, p_ct = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_busy = 0; m_done = 0; m_wrap = 0; m_ctr = 0; m_ks = 0; m_ct = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_ks = p_ks; m_ct = p_ct; m_done = 1; m_busy = 0;
          m_ctr = p_ctr + 1;
          if (p_ctr == 32'hffffffff) m_wrap = 1;
        end
      end else if (start) begin
        p_ctr = ctr_load ? ctr_in : m_ctr;
        p_ks = chacha(chacha_key, chacha_nonce, p_ctr);
        p_ct = message ^ p_ks[255:0];
        if (ctr_load) m_wrap = 0;
        m_left = R + 1; m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy", busy, m_busy);
      chk("done", Done, m_done);
      chk("wrap", ctr_wrap, m_wrap);
      chk("keystream", keystream, m_ks);
      chk("ciphertext", ciphertext, m_ct);
    end
  end

  task automatic go(input logic ld, input logic [31:0] ci, input logic noisy, output int lat);
    ctr_load = ld; ctr_in = ci; start = 1; lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      start = (noisy && lat < 15) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy && lat < 15) begin
        message = {8{$urandom}};
        ctr_load = 1'($urandom_range(0, 1));
      end
    end while (!Done && lat < 100);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, Done, 0);
    chk({nm, "_wrap"}, ctr_wrap, 0);
    chk({nm, "_ks"}, keystream, 0);
    chk({nm, "_ct"}, ciphertext, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [255:0] rfc_key;
    logic [127:0] rfc_nonce;
    logic [511:0] exp_ks;
    logic [127:0] rfc_w;
    int lat, nd, cyc;
    int t [3];
    for (int b = 0; b < 32; b++) rfc_key[8*b +: 8] = 8'(b);
    rfc_nonce = {32'h0, 32'h4a000000, 32'h09000000, 32'h0};
    rfc_w = {32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
    exp_ks = chacha(rfc_key, rfc_nonce, 1);
    chk("model_rfc", exp_ks[127:0], rfc_w);
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    reset_n = 1;
    @(posedge clk); #1;
    chacha_key = rfc_key; chacha_nonce = rfc_nonce; message = 0;
    go(1, 1, 0, lat);
    chk("rfc_latency", lat, 22);
    chk("rfc_ks", keystream[127:0], rfc_w);
    chk("rfc_ct", ciphertext[127:0], rfc_w);
    message = {160'h0, 96'hece498ece498ece498ece498};
    go(0, 0, 0, lat);
    exp_ks = chacha(rfc_key, rfc_nonce, 2);
    chk("auto_ks", keystream, exp_ks);
    chk("auto_ct", ciphertext, message ^ exp_ks[255:0]);
    go(1, 32'hffffffff, 0, lat);
    chk("wrap_flag", ctr_wrap, 1);
    go(0, 0, 0, lat);
    chk("wrap_ctr0", keystream, chacha(rfc_key, rfc_nonce, 0));
    chk("wrap_sticky", ctr_wrap, 1);
    message = 0; ctr_load = 1; ctr_in = 1; start = 1;
    @(posedge clk); #1 start = 0;
    nd = 0;
    for (int c = 1; c <= 40; c++) begin
      start = (c == 5 || c == 10);
      if (start) begin chacha_key = {8{$urandom}}; message = {8{$urandom}}; end
      @(posedge clk); #1;
      if (Done) nd++;
    end
    start = 0;
    chk("iso_dones", nd, 1);
    chk("iso_ks", keystream[127:0], rfc_w);
    chk("iso_wrap_clr", ctr_wrap, 0);
    chacha_key = rfc_key; ctr_load = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (8) @(posedge clk);
    #2 reset_n = 0;
    #1 chk_zero("midrst");
    @(posedge clk); #3 reset_n = 1;
    repeat (3) @(posedge clk); #1;
    go(0, 0, 0, lat);
    chk("rst_latency", lat, 22);
    chk("rst_ctr", keystream, chacha(rfc_key, rfc_nonce, 0));
    ctr_load = 0; start = 1; nd = 0; cyc = 0;
    while (nd < 3 && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (Done) begin
        t[nd] = cyc; nd++;
        if (nd == 3) start = 0;
      end
    end
    start = 0;
    chk("b2b_count", nd, 3);
    chk("b2b_gap1", t[1] - t[0], 22);
    chk("b2b_gap2", t[2] - t[1], 22);
    chk("b2b_ks3", keystream, chacha(rfc_key, rfc_nonce, 3));
    for (int k = 0; k < 12; k++) begin
      chacha_key = {8{$urandom}};
      chacha_nonce = {4{$urandom}};
      message = {8{$urandom}};
      go(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 32'hffffffff : $urandom, 1, lat);
      chk("rand_latency", lat, 22);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1 $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
